// File: rtl/csr_pkg.sv
// Shared CSR addresses, interrupt cause codes, mstatus bit positions and trap FSM
// states for the machine-mode trap sequencer.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [3:0] IRQ_CODE_SW    = 4'd3;
  localparam logic [3:0] IRQ_CODE_TIMER = 4'd7;
  localparam logic [3:0] IRQ_CODE_EXT   = 4'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRAP = 2'd1,
    RET  = 2'd2
  } trap_state_t;

endpackage

// File: rtl/irq_priority_enc.sv
// Picks the highest-priority pending M-mode interrupt: ext > sw > timer.
// pending bit order is {ext, timer, sw}, matching the mip bit order 11/7/3.
module irq_priority_enc
  import csr_pkg::*;
(
  input  logic [2:0] pending,
  output logic       valid,
  output logic [3:0] code
);

  always_comb begin
    valid = |pending;
    code  = '0;
    if (pending[2])      code = IRQ_CODE_EXT;
    else if (pending[0]) code = IRQ_CODE_SW;
    else if (pending[1]) code = IRQ_CODE_TIMER;
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap/interrupt controller: owns mstatus/mie/mip/mtvec/mepc/mcause,
// sequences trap entry and MRET. Define TRAP_VECTORED_EN for vectored mtvec mode.
//
// Handshake: a trap or MRET is accepted only in IDLE with ex_valid_i high; the
// following cycle (TRAP/RET) asserts flush_o and redirect_o together for exactly
// one cycle with redirect_pc_o valid; no back-pressure exists.
module trap_sequencer
  import csr_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_MTVEC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq_ext_i,
  input  logic             irq_sw_i,
  input  logic             irq_timer_i,
  input  logic             ex_valid_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic             mret_i,
  input  logic             csr_we_i,
  input  logic [11:0]      csr_addr_i,
  input  logic [XLEN-1:0]  csr_wdata_i,
  output logic [XLEN-1:0]  csr_rdata_o,
  output logic             flush_o,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output trap_state_t      state_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

`ifdef TRAP_VECTORED_EN
  localparam logic [XLEN-1:0] MTVEC_RST =
    {RESET_MTVEC[XLEN-1:2], 1'b0, (RESET_MTVEC[1:0] == 2'b01)};
`else
  localparam logic [XLEN-1:0] MTVEC_RST = RESET_MTVEC & ALIGN_MASK;
`endif

  trap_state_t     state_q, state_d;
  logic            mstatus_mie_q, mstatus_mpie_q;
  logic [2:0]      mie_q;  // {meie, mtie, msie}
  logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q;
  logic [2:0]      mip, pending;
  logic            irq_valid;
  logic [3:0]      irq_code;
  logic            take_trap, take_ret, csr_write;
  logic [XLEN-1:0] mtvec_wr, trap_target;

  assign mip     = {irq_ext_i, irq_timer_i, irq_sw_i};
  assign pending = mip & mie_q & {3{mstatus_mie_q}};
  assign state_o = state_q;

  irq_priority_enc u_prio (
    .pending (pending),
    .valid   (irq_valid),
    .code    (irq_code)
  );

  // MRET outranks a simultaneous irq; a trap drops the coincident CSR write.
  assign take_ret  = (state_q == IDLE) && ex_valid_i && mret_i;
  assign take_trap = (state_q == IDLE) && ex_valid_i && !mret_i && irq_valid;
  assign csr_write = (state_q == IDLE) && ex_valid_i && csr_we_i && !take_ret && !take_trap;

`ifdef TRAP_VECTORED_EN
  assign mtvec_wr = {csr_wdata_i[XLEN-1:2], 1'b0, (csr_wdata_i[1:0] == 2'b01)};
`else
  assign mtvec_wr = csr_wdata_i & ALIGN_MASK;
`endif

  always_comb begin
    trap_target = mtvec_q & ALIGN_MASK;
`ifdef TRAP_VECTORED_EN
    if (mtvec_q[1:0] == 2'b01) trap_target = trap_target + (XLEN'(mcause_q[3:0]) << 2);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RST;
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else begin
      state_q <= state_d;
      if (take_trap) begin
        mepc_q         <= ex_pc_i & ALIGN_MASK;
        mcause_q       <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (take_ret) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end else if (csr_write) begin
        case (csr_addr_i)
          CSR_MSTATUS: begin
            mstatus_mie_q  <= csr_wdata_i[MSTATUS_MIE];
            mstatus_mpie_q <= csr_wdata_i[MSTATUS_MPIE];
          end
          CSR_MIE:    mie_q    <= {csr_wdata_i[11], csr_wdata_i[7], csr_wdata_i[3]};
          CSR_MTVEC:  mtvec_q  <= mtvec_wr;
          CSR_MEPC:   mepc_q   <= csr_wdata_i & ALIGN_MASK;
          CSR_MCAUSE: mcause_q <= csr_wdata_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    flush_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    case (state_q)
      IDLE: begin
        if (take_ret)       state_d = RET;
        else if (take_trap) state_d = TRAP;
      end
      TRAP: begin
        flush_o       = 1'b1;
        redirect_o    = 1'b1;
        redirect_pc_o = trap_target;
        state_d       = IDLE;
      end
      RET: begin
        flush_o       = 1'b1;
        redirect_o    = 1'b1;
        redirect_pc_o = mepc_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_MSTATUS: begin
        csr_rdata_o[MSTATUS_MIE]                   = mstatus_mie_q;
        csr_rdata_o[MSTATUS_MPIE]                  = mstatus_mpie_q;
        csr_rdata_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      CSR_MIE: begin
        csr_rdata_o[11] = mie_q[2];
        csr_rdata_o[7]  = mie_q[1];
        csr_rdata_o[3]  = mie_q[0];
      end
      CSR_MIP: begin
        csr_rdata_o[11] = mip[2];
        csr_rdata_o[7]  = mip[1];
        csr_rdata_o[3]  = mip[0];
      end
      CSR_MTVEC:  csr_rdata_o = mtvec_q;
      CSR_MEPC:   csr_rdata_o = mepc_q;
      CSR_MCAUSE: csr_rdata_o = mcause_q;
      default:    csr_rdata_o = '0;
    endcase
  end

endmodule
